// File: rtl/serial_deframer_if.sv
// Serial input and word-output handshake bundle for the serial deframer.
// The master side drives the bit stream and the consumer ready; the slave side is the deframer.
interface serial_deframer_if #(
  parameter int N = 8
) ();
  logic         sin;
  logic         sin_en;
  logic         sync;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output sin, sin_en, sync, out_ready,
    input  data_out, out_valid
  );

  modport slave (
    input  sin, sin_en, sync, out_ready,
    output data_out, out_valid
  );
endinterface

// File: rtl/serial_deframer.sv
// LSB-first serial-to-parallel receiver with sync alignment, a one-entry
// valid/ready holding register, sticky overrun/resync flags and a word counter.
module serial_deframer #(
  parameter int N  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  serial_deframer_if.slave bus,
  input  logic          clear_status,
  output logic          locked,
  output logic          overrun,
  output logic          sync_err,
  output logic [CW-1:0] word_cnt
);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [BW-1:0] LAST = BW'(N - 1);

  typedef enum logic {HUNT, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  sr;
  logic [BW-1:0] bcnt;
  logic          start;
  logic          take;
  logic          mid_sync;
  logic          complete;
  logic          free;
  logic [N-1:0]  word;

  always_ff @(posedge clk) begin
    if (!reset) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (bus.sin_en && bus.sync) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = HUNT;
    endcase
  end

  // A sync on the last bit of a word is a resync, so it must not also complete the word.
  always_comb begin
    locked   = (state == RUN);
    start    = (state == HUNT) && bus.sin_en && bus.sync;
    take     = (state == RUN) && bus.sin_en;
    mid_sync = take && bus.sync && (bcnt != '0);
    complete = take && !mid_sync && (bcnt == LAST);
    free     = !bus.out_valid || bus.out_ready;
    word     = {bus.sin, sr[N-1:1]};
  end

  // Bit assembly: the newest bit enters at the MSB, so sr[0] ends up as bit 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (start || take) begin
      sr <= word;
      if (start || mid_sync) bcnt <= BW'(1);
      else if (bcnt == LAST) bcnt <= '0;
      else                   bcnt <= bcnt + 1'b1;
    end
  end

  // Holding register and status: a word that cannot be stored is dropped, never overwrites.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.data_out  <= '0;
      bus.out_valid <= 1'b0;
      word_cnt      <= '0;
      overrun       <= 1'b0;
      sync_err      <= 1'b0;
    end else begin
      if (complete && free) begin
        bus.data_out  <= word;
        bus.out_valid <= 1'b1;
        word_cnt      <= word_cnt + 1'b1;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (complete && !free) overrun <= 1'b1;
      else if (clear_status) overrun <= 1'b0;

      if (mid_sync)          sync_err <= 1'b1;
      else if (clear_status) sync_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: directed scenarios plus randomized traffic
// compared every cycle against a bit-queue reference model.
module tb_serial_deframer;
  localparam int N  = 8;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          clear_status;
  logic          locked;
  logic          overrun;
  logic          sync_err;
  logic [CW-1:0] word_cnt;

  serial_deframer_if #(.N(N)) bus ();

  serial_deframer #(.N(N), .CW(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .clear_status (clear_status),
    .locked       (locked),
    .overrun      (overrun),
    .sync_err     (sync_err),
    .word_cnt     (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: bits of the word in progress are kept as a queue, oldest first.
  bit          m_locked;
  bit          m_bits[$];
  logic [N-1:0]  m_data;
  bit          m_valid;
  bit          m_ov;
  bit          m_se;
  logic [CW-1:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] assemble();
    int w = 0;
    for (int i = 0; i < m_bits.size(); i++) w = w + (int'(m_bits[i]) << i);
    return N'(w);
  endfunction

  task automatic model(input bit s, input bit en, input bit sy, input bit rdy,
                       input bit clr, input bit rst_n);
    bit done = 0;
    bit ov_set = 0;
    bit se_set = 0;
    logic [N-1:0] w = '0;
    if (!rst_n) begin
      m_locked = 0; m_bits.delete(); m_data = '0; m_valid = 0;
      m_ov = 0; m_se = 0; m_cnt = '0;
      return;
    end
    if (en) begin
      if (!m_locked) begin
        if (sy) begin
          m_locked = 1;
          m_bits.delete();
          m_bits.push_back(s);
        end
      end else begin
        if (sy && m_bits.size() != 0) begin
          se_set = 1;
          m_bits.delete();
        end
        m_bits.push_back(s);
        if (m_bits.size() == N) begin
          done = 1;
          w = assemble();
          m_bits.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data = w; m_valid = 1; m_cnt = m_cnt + 1'b1;
      end else begin
        ov_set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (ov_set) m_ov = 1; else if (clr) m_ov = 0;
    if (se_set) m_se = 1; else if (clr) m_se = 0;
  endtask

  // One clock: drive inputs, advance model, then compare every output just after the edge.
  task automatic step(input bit s, input bit en, input bit sy, input bit rdy,
                      input bit clr, input bit rst_n);
    bus.sin = s; bus.sin_en = en; bus.sync = sy; bus.out_ready = rdy;
    clear_status = clr; reset = rst_n;
    @(posedge clk);
    model(s, en, sy, rdy, clr, rst_n);
    #1;
    check("data_out",  32'(bus.data_out),  32'(m_data));
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("locked",    32'(locked),        32'(m_locked));
    check("overrun",   32'(overrun),       32'(m_ov));
    check("sync_err",  32'(sync_err),      32'(m_se));
    check("word_cnt",  32'(word_cnt),      32'(m_cnt));
  endtask

  task automatic idle(input bit rdy, input bit clr);
    step(1'b0, 1'b0, 1'b0, rdy, clr, 1'b1);
  endtask

  // Sends one word LSB first; the last bit uses last_rdy so drain-on-completion can be hit.
  task automatic send_word(input logic [7:0] w, input bit with_sync, input int gap,
                           input bit rdy, input bit last_rdy);
    for (int i = 0; i < N; i++) begin
      step(w[i], 1'b1, with_sync && (i == 0), (i == N - 1) ? last_rdy : rdy, 1'b0, 1'b1);
      for (int g = 0; g < gap; g++) idle(rdy, 1'b0);
    end
  endtask

  initial begin
    bus.sin = 0; bus.sin_en = 0; bus.sync = 0; bus.out_ready = 0;
    clear_status = 0; reset = 0;
    m_bits.delete();

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("reset_data_out", 32'(bus.data_out), 32'h0);
    check("reset_valid",    32'(bus.out_valid), 32'h0);
    check("reset_locked",   32'(locked), 32'h0);
    check("reset_word_cnt", 32'(word_cnt), 32'h0);

    // Basic word
    send_word(8'hA5, 1'b1, 0, 1'b1, 1'b1);
    check("basic_data",   32'(bus.data_out), 32'hA5);
    check("basic_valid",  32'(bus.out_valid), 32'h1);
    check("basic_cnt",    32'(word_cnt), 32'h1);
    check("basic_locked", 32'(locked), 32'h1);
    idle(1'b1, 1'b0);
    check("basic_drain", 32'(bus.out_valid), 32'h0);

    // Gapped strobes
    send_word(8'hA5, 1'b1, 3, 1'b1, 1'b1);
    check("gap_data", 32'(bus.data_out), 32'hA5);
    check("gap_cnt",  32'(word_cnt), 32'h2);
    idle(1'b1, 1'b0);

    // Backpressure: second word dropped
    send_word(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    send_word(8'h81, 1'b0, 0, 1'b0, 1'b0);
    check("bp_data",    32'(bus.data_out), 32'h3C);
    check("bp_overrun", 32'(overrun), 32'h1);
    check("bp_cnt",     32'(word_cnt), 32'h3);
    idle(1'b1, 1'b0);
    check("bp_accept", 32'(bus.out_valid), 32'h0);
    idle(1'b0, 1'b1);
    check("bp_clear", 32'(overrun), 32'h0);

    // Simultaneous drain: 0x81 completes as 0x3C is accepted
    send_word(8'h3C, 1'b0, 0, 1'b0, 1'b0);
    send_word(8'h81, 1'b0, 0, 1'b0, 1'b1);
    check("drain_data",    32'(bus.data_out), 32'h81);
    check("drain_valid",   32'(bus.out_valid), 32'h1);
    check("drain_overrun", 32'(overrun), 32'h0);
    check("drain_cnt",     32'(word_cnt), 32'h5);
    idle(1'b1, 1'b0);

    // Resync mid-word
    step(1, 1, 1, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    send_word(8'h5A, 1'b1, 0, 1'b1, 1'b1);
    check("resync_err",  32'(sync_err), 32'h1);
    check("resync_data", 32'(bus.data_out), 32'h5A);
    idle(1'b1, 1'b1);
    check("resync_clear", 32'(sync_err), 32'h0);
    step(1, 1, 0, 1, 0, 1);
    step(0, 1, 0, 1, 0, 1);
    step(1, 1, 1, 1, 1, 1);
    check("resync_set_wins", 32'(sync_err), 32'h1);

    // Reset mid-operation with a held word and a partial word
    send_word(8'h77, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(i[0], 1, 0, 0, 0, 1);
    check("pre_reset_valid", 32'(bus.out_valid), 32'h1);
    step(0, 0, 0, 0, 0, 0);
    check("mid_reset_data",  32'(bus.data_out), 32'h0);
    check("mid_reset_valid", 32'(bus.out_valid), 32'h0);
    check("mid_reset_cnt",   32'(word_cnt), 32'h0);
    check("mid_reset_err",   32'(sync_err), 32'h0);
    for (int i = 0; i < 2 * N; i++) step(1'($urandom_range(0, 1)), 1, 0, 1, 0, 1);
    check("hunt_valid",  32'(bus.out_valid), 32'h0);
    check("hunt_locked", 32'(locked), 32'h0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 499) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
